// File: rtl/sfq_clocked_gate_n.sv
// Cycle-based model of an N-input RSFQ clocked gate (OR/AND/XOR) with toggle-encoded
// lines, clock-to-output latency, setup/double-pulse violation strobes and a saturating counter.
module sfq_clocked_gate_n #(
    parameter int unsigned N     = 2,
    parameter int unsigned MODE  = 0,
    parameter int unsigned DELAY = 1,
    parameter int unsigned SETUP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  din,
    input  logic          sfq_clk,
    output logic          out,
    output logic          out_pulse,
    output logic [N-1:0]  state,
    output logic          viol_setup,
    output logic          viol_double,
    output logic [15:0]   viol_count
);

    localparam int unsigned AW = (SETUP > 0) ? $clog2(SETUP + 1) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(SETUP);

    logic [N-1:0]  din_q;
    logic          sfq_clk_q;
    logic [N-1:0]  state_q, state_d;
    logic [AW-1:0] age_q [N];
    logic [AW-1:0] age_d [N];
    logic          out_q, out_d;
    logic          out_pulse_q, out_pulse_d;
    logic          viol_setup_q, viol_setup_d;
    logic          viol_double_q, viol_double_d;
    logic [15:0]   viol_count_q, viol_count_d;

    logic [N-1:0]  pulse_c;
    logic [N-1:0]  young_c;
    logic          clk_ev_c;
    logic          res_c;
    logic          eval_c;
    logic          tail_c;
    logic [16:0]   cnt_sum_c;

    assign pulse_c  = din ^ din_q;
    assign clk_ev_c = sfq_clk ^ sfq_clk_q;

    // Per-input age since last pulse, saturating at SETUP
    always_comb begin
        age_d   = age_q;
        young_c = '0;
        for (int i = 0; i < N; i++) begin
            young_c[i] = (age_q[i] < AGE_MAX);
            if (pulse_c[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] < AGE_MAX) begin
                age_d[i] = age_q[i] + AW'(1);
            end
        end
    end

    always_comb begin
        res_c = 1'b0;
        case (MODE)
            1:       res_c = &state_q;
            2:       res_c = ^state_q;
            default: res_c = |state_q;
        endcase
    end

    assign eval_c = clk_ev_c & res_c;

    // Result pipeline; with DELAY=1 the result goes straight to the output register
    generate
        if (DELAY <= 1) begin : g_nopipe
            assign tail_c = eval_c;
        end else begin : g_pipe
            localparam int unsigned PW = DELAY - 1;
            logic [PW-1:0] pipe_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= PW'({pipe_q, eval_c});
                end
            end
            assign tail_c = pipe_q[PW-1];
        end
    endgenerate

    // A pulse coincident with a clock event belongs to the next period
    always_comb begin
        state_d       = clk_ev_c ? pulse_c : (state_q | pulse_c);
        viol_double_d = ~clk_ev_c & (|(pulse_c & state_q));
        viol_setup_d  = clk_ev_c & (SETUP != 0) & ((|(state_q & young_c)) | (|pulse_c));
        out_pulse_d   = tail_c;
        out_d         = out_q ^ tail_c;
        cnt_sum_c     = {1'b0, viol_count_q} + 17'(viol_setup_d) + 17'(viol_double_d);
        viol_count_d  = cnt_sum_c[16] ? 16'hFFFF : cnt_sum_c[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q         <= din;
            sfq_clk_q     <= sfq_clk;
            state_q       <= '0;
            for (int i = 0; i < N; i++) age_q[i] <= AGE_MAX;
            out_q         <= 1'b0;
            out_pulse_q   <= 1'b0;
            viol_setup_q  <= 1'b0;
            viol_double_q <= 1'b0;
            viol_count_q  <= '0;
        end else begin
            din_q         <= din;
            sfq_clk_q     <= sfq_clk;
            state_q       <= state_d;
            for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
            out_q         <= out_d;
            out_pulse_q   <= out_pulse_d;
            viol_setup_q  <= viol_setup_d;
            viol_double_q <= viol_double_d;
            viol_count_q  <= viol_count_d;
        end
    end

    assign out         = out_q;
    assign out_pulse   = out_pulse_q;
    assign state       = state_q;
    assign viol_setup  = viol_setup_q;
    assign viol_double = viol_double_q;
    assign viol_count  = viol_count_q;

endmodule
